// File: rtl/shift_pkg.sv
// Shared encodings and helpers for the pipelined barrel shifter.
package shift_pkg;

  localparam int OP_W      = 3;
  localparam int DEF_WIDTH = 32;

  typedef enum logic [OP_W-1:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } op_e;

  function automatic logic op_rsvd(input logic [OP_W-1:0] op);
    return op > OP_ROR;
  endfunction

  // First level handled by stage s; earlier stages absorb the remainder.
  function automatic int lvl_first(input int s, input int lvls, input int stages);
    int base;
    int rem;
    base = lvls / stages;
    rem  = lvls % stages;
    return s * base + ((s < rem) ? s : rem);
  endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational barrel level: moves data by 2^LVL when en is set.
module shift_level
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LVL   = 0
) (
  input  logic [WIDTH-1:0] d,
  input  logic [OP_W-1:0]  op,
  input  logic             en,
  input  logic             sign,
  output logic [WIDTH-1:0] q
);

  localparam int SH = 1 << LVL;

  logic [WIDTH-1:0] top_mask;
  assign top_mask = ~({WIDTH{1'b1}} >> SH);

  always_comb begin
    q = d;
    if (en) begin
      case (op)
        OP_SLL:  q = d << SH;
        OP_SRL:  q = d >> SH;
        OP_SRA:  q = (d >> SH) | (sign ? top_mask : '0);
        OP_ROL:  q = (d << SH) | (d >> (WIDTH - SH));
        OP_ROR:  q = (d >> SH) | (d << (WIDTH - SH));
        default: q = d;
      endcase
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Logarithmic shifter/rotator split over STAGES registered stages with a
// single global stall; the last stage applies out-of-range saturation.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_err
);

  localparam int LVLS = $clog2(WIDTH);

  logic [STAGES-1:0]            vld_pipe, nxt_vld;
  logic [STAGES-1:0][WIDTH-1:0] r_d, nxt_d;
  logic [STAGES-1:0][OP_W-1:0]  r_op, nxt_op;
  logic [STAGES-1:0][LVLS-1:0]  r_b, nxt_b;
  logic [STAGES-1:0]            r_sg, nxt_sg;
  logic [STAGES-1:0]            r_oob, nxt_oob;
  logic                         adv;

  assign adv      = !(vld_pipe[STAGES-1] && !out_ready);
  assign in_ready = rst_n && adv;

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    localparam int LO = lvl_first(s, LVLS, STAGES);
    localparam int HI = lvl_first(s + 1, LVLS, STAGES);
    localparam int NL = HI - LO;

    logic [WIDTH-1:0]      sd;
    logic [OP_W-1:0]       sop;
    logic [LVLS-1:0]       sb;
    logic                  ssg, soob, sv;
    logic [NL:0][WIDTH-1:0] chain;

    if (s == 0) begin : g_src
      assign sd   = A;
      assign sop  = op;
      assign sb   = B[LVLS-1:0];
      assign ssg  = A[WIDTH-1];
      assign soob = |B[WIDTH-1:LVLS];
      assign sv   = in_valid;
    end else begin : g_src
      assign sd   = r_d[s-1];
      assign sop  = r_op[s-1];
      assign sb   = r_b[s-1];
      assign ssg  = r_sg[s-1];
      assign soob = r_oob[s-1];
      assign sv   = vld_pipe[s-1];
    end

    assign chain[0] = sd;
    for (genvar j = 0; j < NL; j++) begin : g_lvl
      shift_level #(.WIDTH(WIDTH), .LVL(LO + j)) u_lvl (
        .d    (chain[j]),
        .op   (sop),
        .en   (sb[LO+j]),
        .sign (ssg),
        .q    (chain[j+1])
      );
    end

    // Saturate/fill for shift amounts beyond the width; rotates ignore it.
    if (s == STAGES - 1) begin : g_fill
      logic [WIDTH-1:0] fd;
      always_comb begin
        fd = chain[NL];
        if (soob) begin
          case (sop)
            OP_SLL, OP_SRL: fd = '0;
            OP_SRA:         fd = {WIDTH{ssg}};
            default:        fd = chain[NL];
          endcase
        end
      end
      assign nxt_d[s] = fd;
    end else begin : g_fill
      assign nxt_d[s] = chain[NL];
    end

    assign nxt_vld[s] = sv;
    assign nxt_op[s]  = sop;
    assign nxt_b[s]   = sb;
    assign nxt_sg[s]  = ssg;
    assign nxt_oob[s] = soob;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      r_d      <= '0;
      r_op     <= '0;
      r_b      <= '0;
      r_sg     <= '0;
      r_oob    <= '0;
    end else if (adv) begin
      vld_pipe <= nxt_vld;
      r_d      <= nxt_d;
      r_op     <= nxt_op;
      r_b      <= nxt_b;
      r_sg     <= nxt_sg;
      r_oob    <= nxt_oob;
    end
  end

  assign out_valid = vld_pipe[STAGES-1];
  assign out       = r_d[STAGES-1];
  assign out_err   = op_rsvd(r_op[STAGES-1]);

  // Control fields of the final stage (and spent amount bits) have no reader.
  logic unused_ok;
  assign unused_ok = ^{r_b, r_sg, r_oob};

endmodule

// File: tb/tb_shift_pipe.sv
// Directed self-checking bench for shift_pipe (WIDTH=32, STAGES=2).
module tb_shift_pipe;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [2:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_pipe #(.WIDTH(32), .STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_err   (out_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input vec_t v, input logic vld);
    in_valid = vld;
    op = v.op;
    A  = v.a;
    B  = v.b;
  endtask

  vec_t vq[$];
  vec_t sq[$];
  vec_t q0, q1, q2;

  initial begin
    int n, idx, k;
    logic acc, pv;
    logic [32:0] prev;

    // streaming vectors: op, A, B, expected out, expected err
    vq.push_back('{3'd0, 32'h00000001, 32'd31,        32'h80000000, 1'b0});
    vq.push_back('{3'd2, 32'h80000000, 32'd40,        32'hFFFFFFFF, 1'b0});
    vq.push_back('{3'd1, 32'h80000000, 32'd40,        32'h00000000, 1'b0});
    vq.push_back('{3'd4, 32'h000000F1, 32'd36,        32'h1000000F, 1'b0});
    vq.push_back('{3'd3, 32'h80000001, 32'd1,         32'h00000003, 1'b0});
    vq.push_back('{3'd7, 32'h12345678, 32'd5,         32'h12345678, 1'b1});
    vq.push_back('{3'd0, 32'h00000001, 32'd32,        32'h00000000, 1'b0});
    vq.push_back('{3'd1, 32'hFFFFFFFF, 32'd31,        32'h00000001, 1'b0});
    vq.push_back('{3'd2, 32'h80000000, 32'd31,        32'hFFFFFFFF, 1'b0});
    vq.push_back('{3'd2, 32'h7FFFFFFF, 32'd100,       32'h00000000, 1'b0});
    vq.push_back('{3'd3, 32'h12345678, 32'hFFFFFFE4,  32'h23456781, 1'b0});
    vq.push_back('{3'd0, 32'h00000001, 32'h80000000,  32'h00000000, 1'b0});
    vq.push_back('{3'd5, 32'hCAFEBABE, 32'd3,         32'hCAFEBABE, 1'b1});
    vq.push_back('{3'd2, 32'hF0000000, 32'd4,         32'hFF000000, 1'b0});
    vq.push_back('{3'd4, 32'h12345678, 32'd0,         32'h12345678, 1'b0});
    vq.push_back('{3'd0, 32'h0000FFFF, 32'd8,         32'h00FFFF00, 1'b0});

    sq.push_back('{3'd0, 32'h00000001, 32'd1, 32'h00000002, 1'b0});
    sq.push_back('{3'd0, 32'h00000001, 32'd2, 32'h00000004, 1'b0});
    sq.push_back('{3'd1, 32'h00000100, 32'd4, 32'h00000010, 1'b0});
    sq.push_back('{3'd3, 32'hF0000000, 32'd4, 32'h0000000F, 1'b0});
    sq.push_back('{3'd2, 32'h80000000, 32'd1, 32'hC0000000, 1'b0});

    q0 = '{3'd0, 32'h00000001, 32'd4, 32'h00000010, 1'b0};
    q1 = '{3'd7, 32'h0000AAAA, 32'd0, 32'h0000AAAA, 1'b1};
    q2 = '{3'd0, 32'h00000003, 32'd4, 32'h00000030, 1'b0};

    // reset state
    step();
    step();
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_out",   out, 0);
    chk("rst_err",   out_err, 0);
    chk("rst_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("rdy_after_rst", in_ready, 1);

    // back-to-back stream, result of vector i lands two cycles after acceptance
    n = vq.size();
    for (int i = 0; i <= n; i++) begin
      if (i < n) drive(vq[i], 1'b1);
      else       in_valid = 1'b0;
      step();
      if (i == 0) begin
        chk("lat1_valid", out_valid, 0);
      end else begin
        chk($sformatf("v%0d_valid", i-1), out_valid, 1);
        chk($sformatf("v%0d_out", i-1),   out, vq[i-1].e);
        chk($sformatf("v%0d_err", i-1),   out_err, vq[i-1].err);
      end
    end
    step();
    chk("drain_valid", out_valid, 0);

    // five requests against a consumer that stalls for four cycles
    idx = 0;
    k   = 0;
    pv  = 1'b0;
    prev = '0;
    drive(sq[0], 1'b1);
    for (int c = 0; c < 30 && k < 5; c++) begin
      out_ready = (c >= 4);
      #1;
      if (c == 1) chk("stall_rdy_hi", in_ready, 1);
      if (c == 2) chk("stall_rdy_lo", in_ready, 0);
      if (out_valid && !out_ready && pv)
        chk($sformatf("stall_hold%0d", c), {out_err, out}, prev);
      if (out_valid && out_ready) begin
        chk($sformatf("stall_r%0d", k), out, sq[k].e);
        k++;
      end
      acc  = in_valid && in_ready;
      prev = {out_err, out};
      pv   = out_valid;
      step();
      if (acc) idx++;
      if (idx < 5) drive(sq[idx], 1'b1);
      else         in_valid = 1'b0;
    end
    chk("stall_cnt", k, 5);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();

    // reset with two results in flight
    out_ready = 1'b0;
    drive(q0, 1'b1);
    step();
    drive(q1, 1'b1);
    step();
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_rdy", in_ready, 0);
    step();
    chk("flush_valid", out_valid, 0);
    chk("flush_out",   out, 0);
    chk("flush_err",   out_err, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(q2, 1'b1);
    #1;
    chk("post_rst_rdy", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("post_rst_lat1", out_valid, 0);
    step();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_out",   out, q2.e);
    chk("post_rst_err",   out_err, q2.err);
    step();
    chk("post_rst_drain", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits; SHALL be a power of two, 8..64.
REQ-002 Parameter STAGES, default 2: register stages, input to output; SHALL be 1..log2(WIDTH).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  request accepted this cycle when in_valid && in_ready.
REQ-007 A  input  WIDTH  operand.
REQ-008 B  input  WIDTH  shift amount, full width, unsigned.
REQ-009 op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 reserved.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result when out_valid && out_ready.
REQ-012 out  output  WIDTH  result.
REQ-013 out_err  output  1  result came from a reserved op.

Function
REQ-014 SLL/SRL SHALL zero-fill; B >= WIDTH gives all zeros.
REQ-015 SRA SHALL fill with A[WIDTH-1]; B >= WIDTH gives all copies of the sign bit.
REQ-016 ROL/ROR SHALL rotate by B mod WIDTH, using only B[log2(WIDTH)-1:0].
REQ-017 Reserved op SHALL give out = A unshifted and out_err = 1; out_err = 0 for legal ops.
REQ-018 Shift SHALL be logarithmic: log2(WIDTH) binary levels (level k moves 2^k) plus a saturate/fill step for out-of-range B.
REQ-019 Levels SHALL be split across STAGES registered stages, near-even, lower levels first.
REQ-020 Latency: a request accepted in cycle N SHALL appear on out at cycle N+STAGES when there is no stall.
REQ-021 Throughput SHALL be one request per cycle while out_ready = 1.
REQ-022 Each stage SHALL hold a valid bit, partial data, op, residual B bits and the sign bit.
REQ-023 Pipeline advances when !(out_valid && !out_ready); all stages hold otherwise.
REQ-024 in_ready SHALL equal the advance condition; no combinational path from in_valid to in_ready.
REQ-025 While stalled, out, out_err and out_valid SHALL stay stable.
REQ-026 Bubbles SHALL propagate: an empty stage never produces out_valid; no result is dropped or duplicated.
REQ-027 Results SHALL leave in acceptance order.

Reset
REQ-028 With rst_n = 0 at a clock edge, all stage valid bits clear, out_valid = 0, out = 0, out_err = 0.
REQ-029 During reset, in_ready SHALL be 0.
REQ-030 Results in flight when reset is asserted SHALL be discarded and never appear on out.
REQ-031 The first cycle after rst_n rises SHALL accept input normally.

Structure
REQ-032 Package shift_pkg SHALL hold the op encoding constants/typedef, OP_W = 3 and the default WIDTH.
REQ-033 One sub-module, shift_level, SHALL implement one combinational level (parameters: WIDTH, level index).
REQ-034 shift_pipe SHALL instantiate one shift_level per level, with registers at the stage boundaries.

Verification (WIDTH=32, STAGES=2)
REQ-035 SLL, A=0x00000001, B=31, out_ready=1 -> out=0x80000000, out_err=0, exactly 2 cycles after acceptance.
REQ-036 SRA, A=0x80000000, B=40 -> 0xFFFFFFFF; SRL with the same operands -> 0x00000000; back-to-back, in order.
REQ-037 ROR, A=0x000000F1, B=36 -> 0x1000000F; ROL, A=0x80000001, B=1 -> 0x00000003.
REQ-038 Five back-to-back requests with out_ready held 0 for 4 cycles -> in_ready drops once both stages are full; out stable while stalled; all five results delivered in order after release.
REQ-039 rst_n low for 1 cycle with 2 results in flight -> neither appears; out_valid=0 and out=0 after the edge; the next request completes normally.
REQ-040 op=3'b111, A=0x12345678 -> out=0x12345678, out_err=1.
